fft_frame_sched: RTL and testbench
==================================

// Module: fft_frame_sched
// PURPOSE
// Frame scheduler that sequences fft_256 from a continuous audio sample stream.
// Gathers WIDTH-bit samples into a ping-pong pair of N-entry banks and drives the
// full bank onto fft_256.time_samples. Pulses fft_256.start, waits for done, then
// flags a frame for mag_est/display. Sits between the ADC front-end and fft_256.
// PARAMETERS
// WIDTH           12    sample width (matches fft_256 WIDTH)
// N               256   samples per frame (power of 2)
// TIMEOUT_CYCLES  1024  watchdog limit in WAIT, used only with FFT_TIMEOUT_EN
// PORTS
// clk           in   1            system clock, all logic on rising edge
// rst           in   1            asynchronous, active-high reset
// sample_valid  in   1            sample_in valid this cycle
// sample_in     in   WIDTH        signed two's-complement audio sample
// fft_start     out  1            one-cycle start pulse to fft_256
// fft_done      in   1            done from fft_256 (level; rising edge used)
// time_samples  out  [WIDTH-1:0] [0:N-1]  read bank, to fft_256.time_samples
// frame_ready   out  1            one-cycle pulse: fft_256 outputs valid
// busy          out  1            high in START or WAIT
// drop_cnt      out  8            frames discarded on overrun, saturates at 255
// timeout_err   out  1            sticky watchdog flag (0 without FFT_TIMEOUT_EN)
// BEHAVIOUR
// - Reset (async, rst=1): both banks 0, time_samples all 0, wr_bank=0, rd_bank=1,
//   wr_idx=0, FSM=IDLE, fft_start=0, frame_ready=0, busy=0, drop_cnt=0,
//   timeout_err=0, done_q=0. Reset mid-frame or mid-FFT abandons all work.
// - Write side: on sample_valid, bank[wr_bank][wr_idx] <= sample_in, wr_idx++.
//   No sample_valid: nothing changes. Samples are never stalled (no ready port).
// - Frame complete = write at wr_idx==N-1. In that cycle wr_idx wraps to 0 and:
//   * FSM IDLE (or done edge this cycle, see below): rd_bank<=wr_bank,
//     wr_bank<=~wr_bank, FSM->START.
//   * FSM START/WAIT: overrun; frame dropped, wr_bank kept (overwritten next),
//     drop_cnt++ saturating at 255. rd_bank contents untouched.
// - time_samples = bank[rd_bank]; stable from START until next swap (never
//   modified while busy).
// - done_q registers fft_done; done_edge = fft_done & ~done_q.
// - FSM: IDLE -> START on accepted frame. START: fft_start=1 for exactly one cycle,
//   -> WAIT. WAIT: on done_edge -> IDLE and frame_ready=1 next cycle.
//   Done edge in START ignored (stale).
// - Latency: last sample written at edge T -> fft_start high in cycle T+1;
//   done_edge seen at edge D -> frame_ready high in cycle D+1 only.
// - Simultaneous done_edge and frame complete in WAIT: done takes priority; frame
//   accepted, FSM -> START (not IDLE), frame_ready still pulses, no drop.
// - busy = (FSM==START)|(FSM==WAIT), registered with FSM.
// CONFIGURATION
// FFT_TIMEOUT_EN defined: wait counter cleared on entering WAIT, increments per
//   WAIT cycle. On reaching TIMEOUT_CYCLES with no done_edge: FSM->IDLE,
//   timeout_err<=1 (sticky until rst), no frame_ready. Next complete frame starts
//   normally.
// FFT_TIMEOUT_EN undefined: no counter; WAIT held until done_edge indefinitely;
//   timeout_err tied 0.
// TESTING
// 1 Reset: rst=1 mid-stream -> all outputs 0 immediately (async), wr_idx restarts.
// 2 Stream 256 samples 0..255, fft_done after 40 cycles -> one fft_start pulse
//   cycle after sample 255, time_samples[k]==k, frame_ready 1 cycle after done rise.
// 3 Continuous samples every cycle, fft_done held 600 cycles -> 2nd frame dropped,
//   drop_cnt==1, time_samples unchanged during WAIT, wr_bank not toggled.
// 4 Done rise in same cycle as frame's last sample -> no drop, frame_ready pulse,
//   fft_start next cycle, rd_bank toggled.
// 5 fft_done level high through next frame -> only one frame_ready (edge detect).
// 6 FFT_TIMEOUT_EN, TIMEOUT_CYCLES=16, fft_done stuck 0 -> IDLE after 16 WAIT
//   cycles, timeout_err=1, no frame_ready; next frame issues fft_start.
//   Without macro: stays busy, timeout_err=0.

Source files
------------

// File: rtl/fft_frame_sched.sv
// Ping-pong frame scheduler feeding fft_256: fills one bank while the other is analysed.
// Optional watchdog on the WAIT state is enabled by defining FFT_TIMEOUT_EN.
module fft_frame_sched #(
  parameter int WIDTH          = 12,
  parameter int N              = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  output logic             fft_start,
  input  logic             fft_done,
  output logic [WIDTH-1:0] time_samples [0:N-1],
  output logic             frame_ready,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic             timeout_err
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bank0 [0:N-1];
  logic [WIDTH-1:0] bank1 [0:N-1];
  logic             wr_bank, rd_bank;
  logic [IW-1:0]    wr_idx;
  logic             done_q;
  logic             done_edge, frame_done, accept, frame_ready_nxt, timeout_hit;

  assign done_edge  = fft_done & ~done_q;
  assign frame_done = sample_valid && (wr_idx == IW'(N - 1));
  // A done edge in WAIT frees the read bank in the same cycle a frame completes.
  assign accept     = frame_done && ((state == IDLE) || ((state == WAIT) && done_edge));

  assign fft_start  = (state == START);
  assign busy       = (state == START) || (state == WAIT);

`ifdef FFT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == START)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + CW'(1);
      if (timeout_hit)
        timeout_err <= 1'b1;
    end
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) && !done_edge;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    frame_ready_nxt = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (done_edge) begin
          frame_ready_nxt = 1'b1;
          state_nxt       = accept ? START : IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      frame_ready <= 1'b0;
      done_q      <= 1'b0;
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      frame_ready <= frame_ready_nxt;
      done_q      <= fft_done;
      if (sample_valid)
        wr_idx <= wr_idx + IW'(1);
      if (accept) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end else if (frame_done && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (sample_valid) begin
      if (wr_bank)
        bank1[wr_idx] <= sample_in;
      else
        bank0[wr_idx] <= sample_in;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++)
      time_samples[i] = rd_bank ? bank1[i] : bank0[i];
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched (WIDTH=12, N=256, TIMEOUT_CYCLES=16).
// Build with FFT_TIMEOUT_EN defined to exercise the watchdog path.
module tb_fft_frame_sched;

  localparam int W = 12;
  localparam int N = 256;
`ifdef FFT_TIMEOUT_EN
  localparam int DONE_DLY = 10;
`else
  localparam int DONE_DLY = 40;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample_valid = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic         fft_start;
  logic         fft_done = 1'b0;
  logic [W-1:0] ts [0:N-1];
  logic         frame_ready;
  logic         busy;
  logic [7:0]   drop_cnt;
  logic         timeout_err;

  int n_checks = 0;
  int n_err    = 0;
  int fr_cnt   = 0;

  fft_frame_sched #(.WIDTH(W), .N(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .fft_start(fft_start), .fft_done(fft_done), .time_samples(ts),
    .frame_ready(frame_ready), .busy(busy), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_ready) fr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
  endtask

  task automatic reset_dut();
    sample_valid = 1'b0;
    fft_done     = 1'b0;
    rst          = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin : main
    int bad;
    int fr0;

    // Test 1: reset state
    tick();
    chk("rst_fft_start", fft_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_ts0", ts[0], 0);
    rst = 1'b0;
    tick();

    // Test 2: one frame 0..255, done after DONE_DLY cycles
    for (int k = 0; k < N - 1; k++) send(W'(k));
    chk("t2_no_start_early", fft_start, 0);
    send(W'(255));
    chk("t2_fft_start", fft_start, 1);
    chk("t2_busy", busy, 1);
    sample_valid = 1'b0;
    tick();
    chk("t2_start_one_cycle", fft_start, 0);
    chk("t2_busy_wait", busy, 1);
    bad = 0;
    for (int k = 0; k < N; k++) if (ts[k] !== W'(k)) bad++;
    chk("t2_ts_frame", bad, 0);
    chk("t2_ts255", ts[255], 255);
    repeat (DONE_DLY - 2) tick();
    chk("t2_no_ready_yet", frame_ready, 0);
    fft_done = 1'b1;
    tick();
    chk("t2_frame_ready", frame_ready, 1);
    chk("t2_idle", busy, 0);
    tick();
    chk("t2_ready_one_cycle", frame_ready, 0);
    fft_done = 1'b0;
    tick();

    // Test 1b: asynchronous reset mid-stream clears everything at once
    for (int k = 0; k < 100; k++) send(12'h0AA);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_ts5", ts[5], 0);
    chk("t1_async_busy", busy, 0);
    sample_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Test 3: back-to-back frames with fft_done held low
    for (int k = 0; k < N; k++) send(12'h800 | W'(k));
    chk("t3_startA", fft_start, 1);
    for (int k = 0; k < N; k++) send(12'h400 | W'(k));
`ifdef FFT_TIMEOUT_EN
    chk("t3_to_drop", drop_cnt, 0);
    chk("t3_to_startB", fft_start, 1);
    chk("t3_to_ts3", ts[3], 12'h403);
    chk("t3_to_err", timeout_err, 1);
    chk("t3_to_no_ready", fr_cnt, 1);
`else
    chk("t3_drop", drop_cnt, 1);
    chk("t3_no_startB", fft_start, 0);
    chk("t3_busy", busy, 1);
    chk("t3_ts3_held", ts[3], 12'h803);
    chk("t3_timeout_err", timeout_err, 0);
    sample_valid = 1'b0;
    fft_done = 1'b1;
    tick();
    chk("t3_frame_ready", frame_ready, 1);
    chk("t3_idle", busy, 0);
`endif
    reset_dut();

`ifndef FFT_TIMEOUT_EN
    // Test 4: done edge coincides with last sample of next frame
    for (int k = 0; k < N; k++) send(W'(k));
    chk("t4_startA", fft_start, 1);
    for (int k = 0; k < N - 1; k++) send(12'hC00 | W'(k));
    sample_valid = 1'b1;
    sample_in    = 12'hCFF;
    fft_done     = 1'b1;
    tick();
    chk("t4_fft_start", fft_start, 1);
    chk("t4_frame_ready", frame_ready, 1);
    chk("t4_no_drop", drop_cnt, 0);
    chk("t4_ts7_swapped", ts[7], 12'hC07);
    fr0 = fr_cnt;

    // Test 5: fft_done level stays high through the next frame
    for (int k = 0; k < N; k++) send(12'h300 | W'(k));
    sample_valid = 1'b0;
    tick();
    chk("t5_single_ready", fr_cnt - fr0, 1);
    chk("t5_drop", drop_cnt, 1);
    chk("t5_busy", busy, 1);
    chk("t5_ts7_held", ts[7], 12'hC07);
    fft_done = 1'b0;
    tick();
    fft_done = 1'b1;
    tick();
    chk("t5_ready_after_edge", frame_ready, 1);
    tick();
    chk("t5_ready_one_cycle", frame_ready, 0);
`else
    // Test 6: watchdog with fft_done stuck low
    fr0 = fr_cnt;
    for (int k = 0; k < N; k++) send(W'(k));
    sample_valid = 1'b0;
    chk("t6_start", fft_start, 1);
    repeat (16) tick();
    chk("t6_busy_16", busy, 1);
    chk("t6_err_not_yet", timeout_err, 0);
    tick();
    chk("t6_idle", busy, 0);
    chk("t6_err", timeout_err, 1);
    for (int k = 0; k < N; k++) send(W'(k));
    chk("t6_restart", fft_start, 1);
    chk("t6_err_sticky", timeout_err, 1);
    chk("t6_no_ready", fr_cnt - fr0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
